// File: rtl/alu_exec_unit_if.sv
// Upstream instruction handshake between the instruction source (master) and
// the execute unit (slave), plus the retire/reject pulses returned upstream.
interface alu_exec_unit_if #(
   parameter int unsigned INSTR_W = 10
);
   logic [INSTR_W-1:0] ivInstr;
   logic               iValid;
   logic               oReady;
   logic               oDone;
   logic               oError;

   modport master (
      output ivInstr, iValid,
      input  oReady, oDone, oError
   );

   modport slave (
      input  ivInstr, iValid,
      output oReady, oDone, oError
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage around a 4-bit ALU: 4x4 register file, flags register, and a
// two-state IDLE/DRIVE sequencer that issues operands and writes back results.
module alu_exec_unit #(
   parameter int unsigned DATA_W   = 4,
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned ADDR_W   = 2
) (
   input  logic               iClk,
   input  logic               iRst_n,
   alu_exec_unit_if.slave     up,
   output logic [3:0]         ovAluInstr,
   output logic [DATA_W-1:0]  ovAluA,
   output logic [DATA_W-1:0]  ovAluB,
   input  logic [DATA_W-1:0]  ivAluResult,
   input  logic [3:0]         ivAluFlags,
   output logic [3:0]         ovFlags,
   input  logic [ADDR_W-1:0]  ivDbgAddr,
   output logic [DATA_W-1:0]  ovDbgData
);
   localparam int unsigned OP_W    = 4;
   localparam int unsigned FLAG_W  = 4;
   localparam int unsigned INSTR_W = OP_W + 3 * ADDR_W;
   localparam logic [OP_W-1:0] OP_LAST_ALU = OP_W'(10);
   localparam logic [OP_W-1:0] OP_LDI      = OP_W'(15);

   typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [FLAG_W-1:0]   flags_q, flags_d;
   logic [OP_W-1:0]     alu_instr_q, alu_instr_d;
   logic [DATA_W-1:0]   alu_a_q, alu_a_d;
   logic [DATA_W-1:0]   alu_b_q, alu_b_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic                done_q, done_d;
   logic                error_q, error_d;

   logic [OP_W-1:0]     op_c;
   logic [ADDR_W-1:0]   rd_c, ra_c, rb_c;
   logic [DATA_W-1:0]   imm_c;
   logic                accept_c;

   assign op_c     = up.ivInstr[INSTR_W-1 -: OP_W];
   assign rd_c     = up.ivInstr[3*ADDR_W-1 -: ADDR_W];
   assign ra_c     = up.ivInstr[2*ADDR_W-1 -: ADDR_W];
   assign rb_c     = up.ivInstr[ADDR_W-1:0];
   assign imm_c    = up.ivInstr[DATA_W-1:0];
   assign accept_c = up.iValid && (state_q == IDLE);

   // State register
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state: only ALU opcodes take the extra DRIVE cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (accept_c && (op_c <= OP_LAST_ALU)) state_d = DRIVE;
         DRIVE: state_d = IDLE;
      endcase
   end

   // Datapath next values; operands are read at accept, writeback lands in DRIVE
   always_comb begin
      regs_d      = regs_q;
      flags_d     = flags_q;
      alu_instr_d = alu_instr_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      rd_d        = rd_q;
      done_d      = 1'b0;
      error_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               if (op_c <= OP_LAST_ALU) begin
                  alu_instr_d = op_c;
                  alu_a_d     = regs_q[ra_c];
                  alu_b_d     = regs_q[rb_c];
                  rd_d        = rd_c;
               end else if (op_c == OP_LDI) begin
                  regs_d[rd_c] = imm_c;
                  done_d       = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         DRIVE: begin
            regs_d[rd_q] = ivAluResult;
            flags_d      = ivAluFlags;
            done_d       = 1'b1;
         end
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         regs_q      <= '{default: '0};
         flags_q     <= '0;
         alu_instr_q <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         rd_q        <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         flags_q     <= flags_d;
         alu_instr_q <= alu_instr_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         rd_q        <= rd_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign up.oReady  = (state_q == IDLE);
   assign up.oDone   = done_q;
   assign up.oError  = error_q;
   assign ovAluInstr = alu_instr_q;
   assign ovAluA     = alu_a_q;
   assign ovAluB     = alu_b_q;
   assign ovFlags    = flags_q;
   // Debug read port shows the pre-write value on a writeback cycle
   assign ovDbgData  = regs_q[ivDbgAddr];
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a small ALU model on the side port
// (op 0 = ADD, op 1 = SUB, others XOR).
module tb_alu_exec_unit;
   logic       iClk = 1'b0;
   logic       iRst_n = 1'b0;
   logic [3:0] ovAluInstr, ovAluA, ovAluB;
   logic [3:0] ivAluResult, ivAluFlags, ovFlags, ovDbgData;
   logic [1:0] ivDbgAddr = 2'd0;
   logic [4:0] alu_wide;
   logic       alu_c, alu_v;
   int         checks = 0;
   int         failures = 0;

   always #5 iClk = ~iClk;

   alu_exec_unit_if up ();

   alu_exec_unit dut (
      .iClk        (iClk),
      .iRst_n      (iRst_n),
      .up          (up),
      .ovAluInstr  (ovAluInstr),
      .ovAluA      (ovAluA),
      .ovAluB      (ovAluB),
      .ivAluResult (ivAluResult),
      .ivAluFlags  (ivAluFlags),
      .ovFlags     (ovFlags),
      .ivDbgAddr   (ivDbgAddr),
      .ovDbgData   (ovDbgData)
   );

   // ALU model: C is carry for ADD and borrow for SUB
   always_comb begin
      alu_wide = 5'd0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      case (ovAluInstr)
         4'd0: begin
            alu_wide    = {1'b0, ovAluA} + {1'b0, ovAluB};
            ivAluResult = alu_wide[3:0];
            alu_c       = alu_wide[4];
            alu_v       = (ovAluA[3] == ovAluB[3]) && (ivAluResult[3] != ovAluA[3]);
         end
         4'd1: begin
            alu_wide    = {1'b0, ovAluA} - {1'b0, ovAluB};
            ivAluResult = alu_wide[3:0];
            alu_c       = alu_wide[4];
            alu_v       = (ovAluA[3] != ovAluB[3]) && (ivAluResult[3] != ovAluA[3]);
         end
         default: ivAluResult = ovAluA ^ ovAluB;
      endcase
      ivAluFlags = {ivAluResult == 4'd0, ivAluResult[3], alu_c, alu_v};
   end

   task automatic dbg_read(input logic [1:0] a, output logic [3:0] d);
      ivDbgAddr = a;
      #1;
      d = ovDbgData;
   endtask

   task automatic test_reset;
      logic [3:0] d;
      up.iValid  = 1'b0;
      up.ivInstr = '0;
      iRst_n = 1'b0;
      repeat (2) @(posedge iClk);
      @(negedge iClk);
      iRst_n = 1'b1;
      @(negedge iClk);
      checks++;
      if (up.oReady !== 1'b1) begin
         $display("FAIL reset_ready got=%b exp=1", up.oReady); failures++;
      end
      checks++;
      if (ovFlags !== 4'h0) begin
         $display("FAIL reset_flags got=%h exp=0", ovFlags); failures++;
      end
      checks++;
      if ({up.oDone, up.oError} !== 2'b00) begin
         $display("FAIL reset_pulses got=%b%b exp=00", up.oDone, up.oError); failures++;
      end
      checks++;
      if ({ovAluInstr, ovAluA, ovAluB} !== 12'h000) begin
         $display("FAIL reset_alu got=%h%h%h exp=000", ovAluInstr, ovAluA, ovAluB); failures++;
      end
      for (int i = 0; i < 4; i++) begin
         dbg_read(2'(i), d);
         checks++;
         if (d !== 4'h0) begin
            $display("FAIL reset_reg%0d got=%h exp=0", i, d); failures++;
         end
      end
   endtask

   task automatic test_ldi_back_to_back;
      logic [3:0] d;
      @(negedge iClk);
      up.ivInstr = {4'hF, 2'd1, 4'd5};
      up.iValid  = 1'b1;
      @(posedge iClk);
      #1 up.ivInstr = {4'hF, 2'd2, 4'd3};
      @(negedge iClk);
      checks++;
      if (up.oDone !== 1'b1) begin
         $display("FAIL ldi_done1 got=%b exp=1", up.oDone); failures++;
      end
      @(posedge iClk);
      #1 up.iValid = 1'b0;
      @(negedge iClk);
      checks++;
      if (up.oDone !== 1'b1) begin
         $display("FAIL ldi_done2 got=%b exp=1", up.oDone); failures++;
      end
      @(negedge iClk);
      checks++;
      if (up.oDone !== 1'b0) begin
         $display("FAIL ldi_done3 got=%b exp=0", up.oDone); failures++;
      end
      dbg_read(2'd1, d);
      checks++;
      if (d !== 4'd5) begin
         $display("FAIL ldi_r1 got=%h exp=5", d); failures++;
      end
      dbg_read(2'd2, d);
      checks++;
      if (d !== 4'd3) begin
         $display("FAIL ldi_r2 got=%h exp=3", d); failures++;
      end
      checks++;
      if (ovFlags !== 4'h0) begin
         $display("FAIL ldi_flags got=%h exp=0", ovFlags); failures++;
      end
   endtask

   task automatic test_add;
      logic [3:0] d;
      @(negedge iClk);
      up.ivInstr = {4'h0, 2'd0, 2'd1, 2'd2};
      up.iValid  = 1'b1;
      @(posedge iClk);
      #1 up.iValid = 1'b0;
      @(negedge iClk);
      checks++;
      if ({up.oReady, up.oDone} !== 2'b00) begin
         $display("FAIL add_drive_ready_done got=%b%b exp=00", up.oReady, up.oDone); failures++;
      end
      checks++;
      if ({ovAluInstr, ovAluA, ovAluB} !== 12'h053) begin
         $display("FAIL add_operands got=%h%h%h exp=053", ovAluInstr, ovAluA, ovAluB); failures++;
      end
      @(negedge iClk);
      checks++;
      if ({up.oReady, up.oDone} !== 2'b11) begin
         $display("FAIL add_retire got=%b%b exp=11", up.oReady, up.oDone); failures++;
      end
      dbg_read(2'd0, d);
      checks++;
      if (d !== 4'd8) begin
         $display("FAIL add_r0 got=%h exp=8", d); failures++;
      end
      checks++;
      if (ovFlags !== 4'b0101) begin
         $display("FAIL add_flags got=%b exp=0101", ovFlags); failures++;
      end
      @(negedge iClk);
      checks++;
      if (up.oDone !== 1'b0) begin
         $display("FAIL add_done_pulse got=%b exp=0", up.oDone); failures++;
      end
   endtask

   task automatic test_sub;
      logic [3:0] d;
      @(negedge iClk);
      up.ivInstr = {4'h1, 2'd3, 2'd2, 2'd1};
      up.iValid  = 1'b1;
      @(posedge iClk);
      #1 up.iValid = 1'b0;
      @(negedge iClk);
      @(negedge iClk);
      checks++;
      if (up.oDone !== 1'b1) begin
         $display("FAIL sub_done got=%b exp=1", up.oDone); failures++;
      end
      dbg_read(2'd3, d);
      checks++;
      if (d !== 4'b1110) begin
         $display("FAIL sub_r3 got=%b exp=1110", d); failures++;
      end
      checks++;
      if (ovFlags !== 4'b0110) begin
         $display("FAIL sub_flags got=%b exp=0110", ovFlags); failures++;
      end
   endtask

   task automatic test_illegal;
      logic [3:0] d;
      logic [3:0] exp_regs [4];
      exp_regs = '{4'd8, 4'd5, 4'd3, 4'he};
      @(negedge iClk);
      up.ivInstr = {4'hC, 2'd0, 2'd1, 2'd2};
      up.iValid  = 1'b1;
      @(posedge iClk);
      #1 up.iValid = 1'b0;
      @(negedge iClk);
      checks++;
      if ({up.oError, up.oDone, up.oReady} !== 3'b101) begin
         $display("FAIL illegal_pulse got=%b%b%b exp=101", up.oError, up.oDone, up.oReady); failures++;
      end
      checks++;
      if ({ovAluInstr, ovAluA, ovAluB} !== 12'h135) begin
         $display("FAIL illegal_alu got=%h%h%h exp=135", ovAluInstr, ovAluA, ovAluB); failures++;
      end
      checks++;
      if (ovFlags !== 4'b0110) begin
         $display("FAIL illegal_flags got=%b exp=0110", ovFlags); failures++;
      end
      for (int i = 0; i < 4; i++) begin
         dbg_read(2'(i), d);
         checks++;
         if (d !== exp_regs[i]) begin
            $display("FAIL illegal_reg%0d got=%h exp=%h", i, d, exp_regs[i]); failures++;
         end
      end
      @(negedge iClk);
      checks++;
      if (up.oError !== 1'b0) begin
         $display("FAIL illegal_pulse_end got=%b exp=0", up.oError); failures++;
      end
   endtask

   // LDI immediately followed by a dependent ADD reading the just-written register
   task automatic test_back_to_back;
      logic [3:0] d;
      @(negedge iClk);
      up.ivInstr = {4'hF, 2'd1, 4'd7};
      up.iValid  = 1'b1;
      @(posedge iClk);
      #1 up.ivInstr = {4'h0, 2'd2, 2'd1, 2'd1};
      @(posedge iClk);
      #1 up.iValid = 1'b0;
      @(negedge iClk);
      checks++;
      if ({ovAluA, ovAluB, up.oReady} !== 9'b0111_0111_0) begin
         $display("FAIL b2b_operands got=%h%h%b exp=770", ovAluA, ovAluB, up.oReady); failures++;
      end
      @(negedge iClk);
      dbg_read(2'd2, d);
      checks++;
      if (d !== 4'he) begin
         $display("FAIL b2b_r2 got=%h exp=e", d); failures++;
      end
      checks++;
      if (ovFlags !== 4'b0101) begin
         $display("FAIL b2b_flags got=%b exp=0101", ovFlags); failures++;
      end
   endtask

   task automatic test_reset_in_drive;
      logic [3:0] d;
      logic       saw_done;
      saw_done = 1'b0;
      @(negedge iClk);
      up.ivInstr = {4'h0, 2'd0, 2'd1, 2'd2};
      up.iValid  = 1'b1;
      @(posedge iClk);
      #1 up.iValid = 1'b0;
      @(negedge iClk);
      iRst_n = 1'b0;
      @(negedge iClk);
      iRst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge iClk);
         saw_done = saw_done | up.oDone;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         $display("FAIL rstdrive_done got=%b exp=0", saw_done); failures++;
      end
      dbg_read(2'd0, d);
      checks++;
      if (d !== 4'h0) begin
         $display("FAIL rstdrive_r0 got=%h exp=0", d); failures++;
      end
      checks++;
      if (ovFlags !== 4'h0) begin
         $display("FAIL rstdrive_flags got=%h exp=0", ovFlags); failures++;
      end
      checks++;
      if (up.oReady !== 1'b1) begin
         $display("FAIL rstdrive_ready got=%b exp=1", up.oReady); failures++;
      end
   endtask

   initial begin
      test_reset();
      test_ldi_back_to_back();
      test_add();
      test_sub();
      test_illegal();
      test_back_to_back();
      test_reset_in_drive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
